// File: rtl/srt_r2_otfc_if.sv
// srt_r2_otfc_if: digit-in / result-out bundle for the radix-2 SRT
// quotient post-processing stage. The slave modport is the stage itself;
// the master modport is the side that feeds digits and takes results.
interface srt_r2_otfc_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             start_i;
    logic [WIDTH-1:0] d_i;
    logic [SHW-1:0]   shift_i;
    logic             digit_valid_i;
    logic [1:0]       digit_i;
    logic [WIDTH:0]   rem_i;
    logic             digit_ready_o;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [WIDTH-1:0] quo_o;
    logic [WIDTH-1:0] rem_o;
    logic             err_o;

    modport slave (
        input  start_i, d_i, shift_i, digit_valid_i, digit_i, rem_i, res_ready_i,
        output digit_ready_o, res_valid_o, quo_o, rem_o, err_o
    );

    modport master (
        output start_i, d_i, shift_i, digit_valid_i, digit_i, rem_i, res_ready_i,
        input  digit_ready_o, res_valid_o, quo_o, rem_o, err_o
    );
endinterface

// File: rtl/srt_r2_otfc.sv
// srt_r2_otfc: on-the-fly conversion of radix-2 SRT quotient digits into a
// binary quotient, followed by negative-remainder correction and remainder
// denormalisation. The result is held behind a valid/ready handshake.
// Optional feature macro: SRT_DIGIT_CHK_EN (sticky illegal-digit flag on err_o).
module srt_r2_otfc #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    srt_r2_otfc_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        CORR = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qm;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic [SHW-1:0]   r_shift;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_remOut;

    logic             w_startTake;
    logic             w_digitAcc;
    logic             w_lastDigit;
    logic             w_remNeg;
    logic [WIDTH-1:0] w_corrRem;

    // A start is honoured everywhere except HOLD, where it needs the result taken too
    assign w_startTake = bus.start_i && ((r_state != HOLD) || bus.res_ready_i);
    // A restart wins over a digit arriving in the same cycle
    assign w_digitAcc  = (r_state == CONV) && bus.digit_valid_i && !bus.start_i;
    assign w_lastDigit = w_digitAcc && (r_cnt == CW'(WIDTH - 1));

    // The low WIDTH bits of rem+d are all the denormaliser keeps, so the
    // correction add is done at WIDTH bits; the sign comes from the stored MSB
    assign w_remNeg  = r_rem[WIDTH];
    assign w_corrRem = w_remNeg ? (r_rem[WIDTH-1:0] + r_d) : r_rem[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: restart has priority, then digit completion / handshake
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_startTake) w_nextState = CONV;
            CONV: begin
                if (w_startTake)      w_nextState = CONV;
                else if (w_lastDigit) w_nextState = CORR;
            end
            CORR: begin
                if (w_startTake) w_nextState = CONV;
                else             w_nextState = HOLD;
            end
            HOLD: begin
                if (w_startTake)          w_nextState = CONV;
                else if (bus.res_ready_i) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs depend on state only
    assign bus.digit_ready_o = (r_state == CONV);
    assign bus.res_valid_o   = (r_state == HOLD);
    assign bus.quo_o         = r_quo;
    assign bus.rem_o         = r_remOut;

    // Q/QM on-the-fly registers, digit counter, operand capture and result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q      <= '0;
            r_qm     <= '0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_shift  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_remOut <= '0;
        end else if (w_startTake) begin
            r_d     <= bus.d_i;
            r_shift <= bus.shift_i;
            r_q     <= '0;
            r_qm    <= '1;
            r_cnt   <= '0;
        end else if (w_digitAcc) begin
            case (bus.digit_i)
                2'b01: begin
                    r_q  <= {r_q[WIDTH-2:0], 1'b1};
                    r_qm <= {r_q[WIDTH-2:0], 1'b0};
                end
                2'b11: begin
                    r_q  <= {r_qm[WIDTH-2:0], 1'b1};
                    r_qm <= {r_qm[WIDTH-2:0], 1'b0};
                end
                default: begin
                    r_q  <= {r_q[WIDTH-2:0], 1'b0};
                    r_qm <= {r_qm[WIDTH-2:0], 1'b1};
                end
            endcase
            r_cnt <= r_cnt + CW'(1);
            if (w_lastDigit) begin
                r_rem <= bus.rem_i;
            end
        end else if (r_state == CORR) begin
            r_quo    <= w_remNeg ? r_qm : r_q;
            r_remOut <= w_corrRem >> r_shift;
        end
    end

`ifdef SRT_DIGIT_CHK_EN
    logic r_err;

    // Sticky illegal-digit flag, cleared only by an accepted start
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_startTake) begin
            r_err <= 1'b0;
        end else if (w_digitAcc && (bus.digit_i == 2'b10)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err_o = r_err;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule
